pong_match_engine: RTL and testbench

- Next-generation ball/match controller for the Pong datapath. It adds a match state machine (idle, serve, play, point, game over), per-player scores, a win condition and ball speed-up on each paddle hit.
- Paddle heights are supplied by the existing paddle position logic. Ball position, scores and match state go to the renderer and score display.
- All geometry, speed and score limits are parameters.

---
 rtl/pong_match_engine_if.sv | 52 +++++
 rtl/pong_match_engine.sv | 262 ++++++++++++++++++++++++++
 tb/tb_pong_match_engine.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/pong_match_engine_if.sv
// Signal bundle between the Pong match engine and the rest of the video
// datapath (paddle position logic, renderer, score display).
//
// Parameters must match the ones given to pong_match_engine so that the
// coordinate widths line up:
//   TOTAL_WIDTH, TOTAL_HEIGHT : screen size in pixels (sets the x / y widths)
//   SCORE_WIDTH               : width of each score counter
//
// Signals:
//   start_button  : debounced start level
//   paddle_1_pos  : top y of the left paddle
//   paddle_2_pos  : top y of the right paddle
//   ball_pos_x/y  : top-left corner of the ball
//   score_1/2     : left / right player scores
//   game_state    : 0 IDLE, 1 SERVE, 2 PLAY, 3 POINT, 4 GAME_OVER
//   game_over     : high while in GAME_OVER
//   hit_pulse     : one-clock pulse on a paddle deflection
//   point_pulse   : one-clock pulse when a point is awarded
//
// Modports: master = the match engine, slave = the surrounding datapath.
interface pong_match_engine_if #(
  parameter int TOTAL_WIDTH  = 640,
  parameter int TOTAL_HEIGHT = 480,
  parameter int SCORE_WIDTH  = 4
);
  localparam int W = $clog2(TOTAL_WIDTH + 1);
  localparam int H = $clog2(TOTAL_HEIGHT + 1);

  logic                   start_button;
  logic [H:0]             paddle_1_pos;
  logic [H:0]             paddle_2_pos;
  logic [W:0]             ball_pos_x;
  logic [H:0]             ball_pos_y;
  logic [SCORE_WIDTH-1:0] score_1;
  logic [SCORE_WIDTH-1:0] score_2;
  logic [2:0]             game_state;
  logic                   game_over;
  logic                   hit_pulse;
  logic                   point_pulse;

  modport master (
    input  start_button, paddle_1_pos, paddle_2_pos,
    output ball_pos_x, ball_pos_y, score_1, score_2,
           game_state, game_over, hit_pulse, point_pulse
  );

  modport slave (
    output start_button, paddle_1_pos, paddle_2_pos,
    input  ball_pos_x, ball_pos_y, score_1, score_2,
           game_state, game_over, hit_pulse, point_pulse
  );
endinterface

// File: rtl/pong_match_engine.sv
// Pong ball / match controller: match state machine (idle, serve, play,
// point, game over), per-player scores, win detection and a ball step
// period that shortens on every paddle hit.
//
// Ports:
//   clk : system clock
//   rst : asynchronous, active-low reset
//   bus : pong_match_engine_if.master (start button and paddle heights in;
//         ball position, scores, match state and event pulses out)
//
// Optional build macro SERVE_RANDOM_EN: adds an 8-bit LFSR that randomises
// the serve height and vertical direction. Without it every serve starts at
// (INITIAL_BALL_X, INITIAL_BALL_Y) heading up.
module pong_match_engine #(
  parameter int TOTAL_WIDTH        = 640,
  parameter int TOTAL_HEIGHT       = 480,
  parameter int BORDER_PIXEL_WIDTH = 8,
  parameter int PADDLE_WIDTH       = 8,
  parameter int PADDLE_HEIGHT      = 64,
  parameter int PADDLE_1_X         = 32,
  parameter int PADDLE_2_X         = 600,
  parameter int BALL_SIDE_SIZE     = 8,
  parameter int INITIAL_BALL_X     = 316,
  parameter int INITIAL_BALL_Y     = 236,
  parameter int BASE_STEP_CLOCKS   = 250000,
  parameter int MIN_STEP_CLOCKS    = 50000,
  parameter int STEP_DECREMENT     = 25000,
  parameter int SERVE_DELAY_STEPS  = 60,
  parameter int SCORE_WIDTH        = 4,
  parameter int WIN_SCORE          = 9
) (
  input  logic               clk,
  input  logic               rst,
  pong_match_engine_if.master bus
);
  localparam int XW  = $clog2(TOTAL_WIDTH + 1) + 1;
  localparam int YW  = $clog2(TOTAL_HEIGHT + 1) + 1;
  localparam int PW  = $clog2(BASE_STEP_CLOCKS + 1);
  localparam int SVW = $clog2(SERVE_DELAY_STEPS + 1);

  localparam int LEFT_FACE  = PADDLE_1_X + PADDLE_WIDTH;
  localparam int RIGHT_FACE = PADDLE_2_X - BALL_SIDE_SIZE;
  localparam int LOW_LIMIT  = BORDER_PIXEL_WIDTH;
  localparam int Y_HIGH     = TOTAL_HEIGHT - BORDER_PIXEL_WIDTH - BALL_SIDE_SIZE;
  localparam int X_HIGH     = TOTAL_WIDTH - BORDER_PIXEL_WIDTH - BALL_SIDE_SIZE;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_POINT = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  state_t                 state_reg, state_next;
  logic [XW-1:0]          x_reg, x_next;
  logic [YW-1:0]          y_reg, y_next;
  logic                   dx_neg_reg, dx_neg_next;   // 1: moving left
  logic                   dy_neg_reg, dy_neg_next;   // 1: moving up
  logic [SCORE_WIDTH-1:0] score_1_reg, score_1_next;
  logic [SCORE_WIDTH-1:0] score_2_reg, score_2_next;
  logic [PW-1:0]          period_reg, period_next;
  logic [PW-1:0]          step_reg, step_next;
  logic [SVW-1:0]         serve_reg, serve_next;
  logic                   hit_reg, hit_next;
  logic                   point_reg, point_next;
  logic                   award_2_reg, award_2_next; // last point went to player 2
  logic                   start_q_reg;

  logic                   start_rise, running, tick, won;
  logic                   hit_left, hit_right;
  logic [YW-1:0]          serve_y;
  logic                   serve_dy_neg;
  logic [PW-1:0]          faster_period;
  int                     cx, cy, p1, p2;

`ifdef SERVE_RANDOM_EN
  logic [7:0] lfsr_reg;

  // Fibonacci LFSR, taps 8,6,5,4
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr_reg <= 8'h01;
    else      lfsr_reg <= {lfsr_reg[6:0], lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};
  end

  assign serve_y      = YW'(INITIAL_BALL_Y + int'(lfsr_reg[3:0]) - 8);
  assign serve_dy_neg = ~lfsr_reg[4];
`else
  assign serve_y      = YW'(INITIAL_BALL_Y);
  assign serve_dy_neg = 1'b1;
`endif

  assign start_rise = bus.start_button & ~start_q_reg;
  assign running    = (state_reg == S_SERVE) || (state_reg == S_PLAY);
  assign tick       = running && (step_reg == period_reg - PW'(1));

  // Candidate position is evaluated signed so the border tests work even
  // when a step would cross zero.
  assign cx = int'(x_reg) + (dx_neg_reg ? -1 : 1);
  assign cy = int'(y_reg) + (dy_neg_reg ? -1 : 1);
  assign p1 = int'(bus.paddle_1_pos);
  assign p2 = int'(bus.paddle_2_pos);

  // Face crossing: the ball was outside the face and this step reaches it.
  assign hit_left  = dx_neg_reg && (int'(x_reg) > LEFT_FACE) && (cx <= LEFT_FACE) &&
                     (cy + BALL_SIDE_SIZE > p1) && (cy < p1 + PADDLE_HEIGHT);
  assign hit_right = !dx_neg_reg && (int'(x_reg) < RIGHT_FACE) && (cx >= RIGHT_FACE) &&
                     (cy + BALL_SIDE_SIZE > p2) && (cy < p2 + PADDLE_HEIGHT);

  assign faster_period = (int'(period_reg) - STEP_DECREMENT >= MIN_STEP_CLOCKS) ?
                         PW'(int'(period_reg) - STEP_DECREMENT) : PW'(MIN_STEP_CLOCKS);

  // Score is bumped on entry to POINT, so POINT only has to compare it.
  assign won = award_2_reg ? (score_2_reg == SCORE_WIDTH'(WIN_SCORE))
                           : (score_1_reg == SCORE_WIDTH'(WIN_SCORE));

  always_comb begin
    state_next   = state_reg;
    x_next       = x_reg;
    y_next       = y_reg;
    dx_neg_next  = dx_neg_reg;
    dy_neg_next  = dy_neg_reg;
    score_1_next = score_1_reg;
    score_2_next = score_2_reg;
    period_next  = period_reg;
    serve_next   = serve_reg;
    award_2_next = award_2_reg;
    hit_next     = 1'b0;
    point_next   = 1'b0;
    // Every state change out of SERVE/PLAY happens on a tick, so wrapping on
    // tick also clears the counter on entry to the next running state.
    step_next    = (running && !tick) ? step_reg + PW'(1) : '0;

    case (state_reg)
      S_IDLE: begin
        if (start_rise) begin
          state_next  = S_SERVE;
          x_next      = XW'(INITIAL_BALL_X);
          y_next      = serve_y;
          dx_neg_next = 1'b1;
          dy_neg_next = serve_dy_neg;
        end
      end

      S_SERVE: begin
        if (tick) begin
          if (int'(serve_reg) + 1 >= SERVE_DELAY_STEPS) begin
            state_next = S_PLAY;
            serve_next = '0;
          end else begin
            serve_next = serve_reg + SVW'(1);
          end
        end
      end

      S_PLAY: begin
        if (tick) begin
          if (cy <= LOW_LIMIT) begin
            y_next      = YW'(LOW_LIMIT);
            dy_neg_next = 1'b0;
          end else if (cy >= Y_HIGH) begin
            y_next      = YW'(Y_HIGH);
            dy_neg_next = 1'b1;
          end else begin
            y_next = YW'(cy);
          end

          if (hit_left) begin
            x_next      = XW'(LEFT_FACE);
            dx_neg_next = 1'b0;
            hit_next    = 1'b1;
            period_next = faster_period;
          end else if (hit_right) begin
            x_next      = XW'(RIGHT_FACE);
            dx_neg_next = 1'b1;
            hit_next    = 1'b1;
            period_next = faster_period;
          end else if (cx <= LOW_LIMIT) begin
            state_next   = S_POINT;
            award_2_next = 1'b1;
            score_2_next = score_2_reg + SCORE_WIDTH'(1);
            point_next   = 1'b1;
          end else if (cx >= X_HIGH) begin
            state_next   = S_POINT;
            award_2_next = 1'b0;
            score_1_next = score_1_reg + SCORE_WIDTH'(1);
            point_next   = 1'b1;
          end else begin
            x_next = XW'(cx);
          end
        end
      end

      S_POINT: begin
        state_next  = won ? S_OVER : S_SERVE;
        x_next      = XW'(INITIAL_BALL_X);
        y_next      = serve_y;
        dy_neg_next = serve_dy_neg;
        // serve toward the player who just conceded
        dx_neg_next = award_2_reg;
        period_next = PW'(BASE_STEP_CLOCKS);
      end

      S_OVER: begin
        if (start_rise) begin
          state_next   = S_SERVE;
          score_1_next = '0;
          score_2_next = '0;
          x_next       = XW'(INITIAL_BALL_X);
          y_next       = serve_y;
          dx_neg_next  = 1'b1;
          dy_neg_next  = serve_dy_neg;
        end
      end

      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= S_IDLE;
      x_reg       <= XW'(INITIAL_BALL_X);
      y_reg       <= YW'(INITIAL_BALL_Y);
      dx_neg_reg  <= 1'b1;
      dy_neg_reg  <= 1'b1;
      score_1_reg <= '0;
      score_2_reg <= '0;
      period_reg  <= PW'(BASE_STEP_CLOCKS);
      step_reg    <= '0;
      serve_reg   <= '0;
      hit_reg     <= 1'b0;
      point_reg   <= 1'b0;
      award_2_reg <= 1'b0;
      start_q_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      x_reg       <= x_next;
      y_reg       <= y_next;
      dx_neg_reg  <= dx_neg_next;
      dy_neg_reg  <= dy_neg_next;
      score_1_reg <= score_1_next;
      score_2_reg <= score_2_next;
      period_reg  <= period_next;
      step_reg    <= step_next;
      serve_reg   <= serve_next;
      hit_reg     <= hit_next;
      point_reg   <= point_next;
      award_2_reg <= award_2_next;
      start_q_reg <= bus.start_button;
    end
  end

  assign bus.ball_pos_x  = x_reg;
  assign bus.ball_pos_y  = y_reg;
  assign bus.score_1     = score_1_reg;
  assign bus.score_2     = score_2_reg;
  assign bus.game_state  = state_reg;
  assign bus.game_over   = (state_reg == S_OVER);
  assign bus.hit_pulse   = hit_reg;
  assign bus.point_pulse = point_reg;
endmodule

// File: tb/tb_pong_match_engine.sv
// Directed bench for pong_match_engine. Unit A uses the default geometry
// with a short step period (6, -2 per hit, floor 3, 2 serve ticks); unit B
// moves the serve height to 284 so that the ball meets the top border and
// the left paddle face on the same step.
module tb_pong_match_engine;
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   tests_run = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pong_match_engine_if a_if ();
  pong_match_engine_if b_if ();

  pong_match_engine #(
    .BASE_STEP_CLOCKS (6),
    .MIN_STEP_CLOCKS  (3),
    .STEP_DECREMENT   (2),
    .SERVE_DELAY_STEPS(2)
  ) dut_a (
    .clk(clk),
    .rst(rst),
    .bus(a_if.master)
  );

  pong_match_engine #(
    .INITIAL_BALL_Y   (284),
    .BASE_STEP_CLOCKS (2),
    .MIN_STEP_CLOCKS  (1),
    .STEP_DECREMENT   (1),
    .SERVE_DELAY_STEPS(1)
  ) dut_b (
    .clk(clk),
    .rst(rst),
    .bus(b_if.master)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = %0d", tag, got);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // which: 0 = unit A hit_pulse, 1 = unit A point_pulse, 2 = unit B hit_pulse
  task automatic wait_for(input int which, input int budget, input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      step(1);
      case (which)
        0:       seen = a_if.hit_pulse;
        1:       seen = a_if.point_pulse;
        default: seen = b_if.hit_pulse;
      endcase
    end
    check({tag, "_seen"}, {31'd0, seen}, 1);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int tp;
    rst = 1'b0;
    a_if.start_button = 1'b0;
    a_if.paddle_1_pos = 52;
    a_if.paddle_2_pos = 316;
    b_if.start_button = 1'b0;
    b_if.paddle_1_pos = 0;
    b_if.paddle_2_pos = 0;
    step(3);
    check("rst_state", a_if.game_state, 0);
    check("rst_ball_x", a_if.ball_pos_x, 316);
    check("rst_ball_y", a_if.ball_pos_y, 236);
    check("rst_scores", {a_if.score_1, a_if.score_2}, 0);
    check("rst_flags", {a_if.hit_pulse, a_if.point_pulse, a_if.game_over}, 0);

    rst = 1'b1;
    step(2);
    check("idle_hold", a_if.game_state, 0);

    // start edge, serve hold, play entry after 2 serve ticks of 6 clocks
    a_if.start_button = 1'b1;
    step(1);
    t0 = cyc;
    check("serve_entry", a_if.game_state, 1);
    a_if.start_button = 1'b0;
    step(11);
    check("serve_hold", a_if.game_state, 1);
    step(1);
    check("play_entry", a_if.game_state, 2);
    check("play_x0", a_if.ball_pos_x, 316);
    check("play_y0", a_if.ball_pos_y, 236);
    step(6);
    check("first_step_x", a_if.ball_pos_x, 315);
    check("first_step_y", a_if.ball_pos_y, 235);

    // start edge during PLAY is ignored
    a_if.start_button = 1'b1;
    step(1);
    check("start_ignored", a_if.game_state, 2);
    a_if.start_button = 1'b0;

    // top bounce at y=8, then left paddle hit at the face x=40, y=56
    wait_for(0, 2000, "hit1");
    check("hit1_cycle", cyc - t0, 1668);
    check("hit1_x", a_if.ball_pos_x, 40);
    check("hit1_y", a_if.ball_pos_y, 56);
    step(1);
    check("hit1_pulse_len", a_if.hit_pulse, 0);
    step(2);
    check("period4_hold_x", a_if.ball_pos_x, 40);
    step(1);
    check("period4_step_x", a_if.ball_pos_x, 41);
    check("period4_step_y", a_if.ball_pos_y, 57);

    // bottom bounce, then right paddle hit at x=592, y=320; period floors at 3
    wait_for(0, 3000, "hit2");
    check("hit2_cycle", cyc - t0, 3876);
    check("hit2_x", a_if.ball_pos_x, 592);
    check("hit2_y", a_if.ball_pos_y, 320);
    a_if.paddle_1_pos = 400;
    a_if.paddle_2_pos = 400;
    step(2);
    check("period3_hold_x", a_if.ball_pos_x, 592);
    step(1);
    check("period3_step_x", a_if.ball_pos_x, 591);
    check("period3_step_y", a_if.ball_pos_y, 319);

    // left miss: ball passes the face at y=248 and reaches x<=8
    wait_for(1, 3000, "miss_left");
    check("miss_left_cycle", cyc - t0, 5628);
    check("point_state", a_if.game_state, 3);
    step(1);
    check("after_point_state", a_if.game_state, 1);
    check("after_point_score2", a_if.score_2, 1);
    check("after_point_score1", a_if.score_1, 0);
    check("after_point_x", a_if.ball_pos_x, 316);
    check("after_point_y", a_if.ball_pos_y, 236);
    check("point_pulse_len", a_if.point_pulse, 0);
    a_if.paddle_1_pos = 52;
    step(12);
    check("reserve_play", a_if.game_state, 2);
    step(6);
    check("reserve_dx_left", a_if.ball_pos_x, 315);

    // same rally shape, but the right paddle is away: player 1 scores
    wait_for(0, 2000, "hit3");
    check("hit3_cycle", cyc - t0, 7297);
    wait_for(1, 3000, "miss_right");
    check("miss_right_cycle", cyc - t0, 9633);
    tp = cyc;
    step(1);
    check("score1_first", a_if.score_1, 1);
    check("serve_after_right", a_if.game_state, 1);

    // serves now head right; each rally is a straight right miss
    for (int i = 2; i <= 9; i++) begin
      wait_for(1, 2500, "rally");
      check("rally_len", cyc - tp, 1861);
      tp = cyc;
      step(1);
      check("rally_score1", a_if.score_1, i);
      check("rally_state", a_if.game_state, (i == 9) ? 4 : 1);
    end
    check("game_over_flag", a_if.game_over, 1);
    check("over_score2", a_if.score_2, 1);
    check("over_x", a_if.ball_pos_x, 316);
    step(20);
    check("frozen_x", a_if.ball_pos_x, 316);
    check("frozen_y", a_if.ball_pos_y, 236);
    check("frozen_state", a_if.game_state, 4);
    check("frozen_score1", a_if.score_1, 9);

    // restart from GAME_OVER
    a_if.start_button = 1'b1;
    step(1);
    check("restart_state", a_if.game_state, 1);
    check("restart_scores", {a_if.score_1, a_if.score_2}, 0);
    a_if.start_button = 1'b0;
    step(72);
    check("midplay_x", a_if.ball_pos_x, 306);
    check("midplay_y", a_if.ball_pos_y, 226);

    // asynchronous reset between clock edges
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_state", a_if.game_state, 0);
    check("async_rst_x", a_if.ball_pos_x, 316);
    check("async_rst_y", a_if.ball_pos_y, 236);
    check("async_rst_flags", {a_if.hit_pulse, a_if.point_pulse, a_if.game_over}, 0);
    step(2);
    rst = 1'b1;
    step(1);

    // unit B: top bounce and left paddle hit on the same step
    b_if.start_button = 1'b1;
    step(1);
    t0 = cyc;
    check("b_serve_entry", b_if.game_state, 1);
    b_if.start_button = 1'b0;
    wait_for(2, 1000, "corner_hit");
    check("corner_cycle", cyc - t0, 554);
    check("corner_x", b_if.ball_pos_x, 40);
    check("corner_y", b_if.ball_pos_y, 8);
    step(1);
    check("corner_next_x", b_if.ball_pos_x, 41);
    check("corner_next_y", b_if.ball_pos_y, 9);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
